glitch_result_checker: RTL and testbench
========================================

// Module: glitch_result_checker
// PURPOSE
//  Consumer stage directly downstream of the registered-sum stage (finout/DV_3).
//  Keeps a FIFO of golden sums computed from the operands issued at the pipeline head.
//  On each DV_3 it compares finout against the oldest golden value and counts faults.
//  It emits a 3-byte result frame per compare on a valid/ready byte stream to the UART TX path.
// PARAMETERS
//  WIDTH  8   data width of operands, finout and golden values (frame bytes assume 8)
//  DEPTH  4   golden FIFO entries (power of 2, >=2)
//  CNT_W  16  width of fault/total counters
// PORTS
//  glitched_clk  in   1        clock; all logic in this domain
//  rst           in   1        reset: rst, synchronous, active-low; clock glitched_clk
//  op_a          in   WIDTH    operand A, sampled when op_valid=1
//  op_b          in   WIDTH    operand B, sampled when op_valid=1
//  op_valid      in   1        operand issue strobe, same cycle the first stage launches
//  finout        in   WIDTH    observed (possibly glitched) sum from the previous stage
//  DV_3          in   1        finout valid strobe
//  clr_cnt       in   1        clears counters and sticky flags
//  tx_ready      in   1        UART TX accepts tx_data this cycle
//  tx_data       out  8        frame byte
//  tx_valid      out  1        tx_data valid
//  fault_cnt     out  CNT_W    mismatching compares, saturating
//  total_cnt     out  CNT_W    all compares, saturating
//  fault_flag    out  1        sticky: at least one mismatch seen
//  ovf_flag      out  1        sticky: push attempted with FIFO full and no pop
//  orphan_flag   out  1        sticky: DV_3 arrived with FIFO empty
//  drop_flag     out  1        sticky: compare result arrived while a frame was pending
// BEHAVIOUR
//  Reset (rst=0 at clock edge): FIFO empty, FSM IDLE, every output 0.
//  Golden: (op_a+op_b) mod 2^WIDTH, carry discarded. Pushed on op_valid.
//  Push when full: dropped and ovf_flag set, unless a pop happens the same cycle.
//  Push and pop in the same cycle: both take effect and the count is unchanged.
//  Pointers wrap modulo DEPTH.
//  DV_3=1, FIFO non-empty: pop the oldest entry and compare. mismatch = (finout != golden).
//  DV_3=1, FIFO empty: set orphan_flag. No count change and no frame.
//  Compare at edge N: counters/flags update at N+1. total_cnt+1; fault_cnt+1 if mismatch.
//  Counters hold at all-ones (saturate).
//  clr_cnt=1: counters and all sticky flags go to 0 next edge.
//  clr_cnt coincident with a compare: clear wins and that compare is not counted.
//  Its frame is still sent.
//  Frame: byte0 = 0xA5 (match) or 0x5A (mismatch), byte1 = observed finout, byte2 = golden.
//  The compare loads a frame register (3 bytes) and the FSM goes IDLE->HDR at N+1.
//  tx_valid=1 from N+1 with tx_data=byte0.
//  FSM: IDLE -(frame loaded)-> HDR -(tx_ready)-> OBS -(tx_ready)-> GLD -(tx_ready)-> IDLE.
//  tx_valid=1 in HDR/OBS/GLD and 0 in IDLE.
//  tx_data stays stable while tx_valid=1 and tx_ready=0.
//  Compare while the FSM is not IDLE: counters update normally, the new frame is discarded
//  and drop_flag is set. Compare in the same cycle GLD completes: frame accepted, IDLE skipped.
//  Reset mid-frame: the frame is abandoned, tx_valid=0 next edge, FIFO flushed.
// TESTING
//  T1 rst=0 2 cycles -> all outputs 0, tx_valid=0.
//  T2 op 0x12+0x34, DV_3 later with finout=0x46, tx_ready=1 -> bytes A5,46,46;
//     total_cnt=1, fault_cnt=0.
//  T3 op 0xF0+0x20, finout=0x11 -> golden 0x10 (wrap); bytes 5A,11,10;
//     fault_cnt=1, fault_flag=1.
//  T4 5 op_valid with DEPTH=4 and no DV_3 -> ovf_flag=1; then 4 DV_3 compare entries 1-4
//     in order; a 5th DV_3 -> orphan_flag=1.
//  T5 tx_ready=0 for 10 cycles -> tx_data=0xA5 held. A second DV_3 meanwhile ->
//     drop_flag=1, total_cnt=2.
//  T6 fault_cnt at 0xFFFF plus mismatch -> stays 0xFFFF. clr_cnt with DV_3 -> counters 0.

Source files
------------

// File: rtl/glitch_result_checker_if.sv
// Operand issue, observed-result and UART TX byte-stream signals of the glitch result checker.
// master = upstream/test side, slave = checker.
interface glitch_result_checker_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic [WIDTH-1:0] finout;
    logic             DV_3;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;

    modport master (
        output op_a, op_b, op_valid, finout, DV_3, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  op_a, op_b, op_valid, finout, DV_3, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/glitch_result_checker.sv
// Compares observed pipeline sums against a FIFO of golden sums, counts faults and
// streams a 3-byte result frame per compare out over a valid/ready byte interface.
module glitch_result_checker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  glitched_clk,
    input  logic                  rst,
    glitch_result_checker_if.slave bus,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      fault_cnt,
    output logic [CNT_W-1:0]      total_cnt,
    output logic                  fault_flag,
    output logic                  ovf_flag,
    output logic                  orphan_flag,
    output logic                  drop_flag
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StHdr, StObs, StGld} state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             empty, full, pop, push, mismatch;
    logic [WIDTH-1:0] golden_in, golden_out;

    state_e           state_q, state_d;
    logic             frame_load;
    logic [7:0]       hdr_q;
    logic [WIDTH-1:0] obs_q, gld_q;

    logic [CNT_W-1:0] fault_cnt_q, total_cnt_q;
    logic             fault_flag_q, ovf_flag_q, orphan_flag_q, drop_flag_q;

    assign empty      = (count_q == '0);
    assign full       = (count_q == Full);
    assign pop        = bus.DV_3 && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for this push.
    assign push       = bus.op_valid && (!full || pop);
    assign golden_in  = bus.op_a + bus.op_b;
    assign golden_out = mem_q[rd_ptr_q];
    assign mismatch   = (bus.finout != golden_out);

    always_ff @(posedge glitched_clk) begin
        if (push) mem_q[wr_ptr_q] <= golden_in;
    end

    always_ff @(posedge glitched_clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
        end
    end

    // Frames are only accepted when the TX path is idle or finishing its last byte.
    always_comb begin
        state_d    = state_q;
        frame_load = 1'b0;
        unique case (state_q)
            StIdle: if (pop) begin
                frame_load = 1'b1;
                state_d    = StHdr;
            end
            StHdr: if (bus.tx_ready) state_d = StObs;
            StObs: if (bus.tx_ready) state_d = StGld;
            StGld: if (bus.tx_ready) begin
                if (pop) begin
                    frame_load = 1'b1;
                    state_d    = StHdr;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge glitched_clk) begin
        if (!rst) begin
            state_q <= StIdle;
            hdr_q   <= '0;
            obs_q   <= '0;
            gld_q   <= '0;
        end else begin
            state_q <= state_d;
            if (frame_load) begin
                hdr_q <= mismatch ? 8'h5A : 8'hA5;
                obs_q <= bus.finout;
                gld_q <= golden_out;
            end
        end
    end

    always_comb begin
        bus.tx_valid = (state_q != StIdle);
        bus.tx_data  = '0;
        unique case (state_q)
            StHdr:   bus.tx_data = hdr_q;
            StObs:   bus.tx_data = 8'(obs_q);
            StGld:   bus.tx_data = 8'(gld_q);
            default: bus.tx_data = '0;
        endcase
    end

    always_ff @(posedge glitched_clk) begin
        if (!rst || clr_cnt) begin
            fault_cnt_q   <= '0;
            total_cnt_q   <= '0;
            fault_flag_q  <= 1'b0;
            ovf_flag_q    <= 1'b0;
            orphan_flag_q <= 1'b0;
            drop_flag_q   <= 1'b0;
        end else begin
            if (pop && total_cnt_q != '1) total_cnt_q <= total_cnt_q + CNT_W'(1);
            if (pop && mismatch && fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + CNT_W'(1);
            if (pop && mismatch) fault_flag_q <= 1'b1;
            if (bus.op_valid && full && !pop) ovf_flag_q <= 1'b1;
            if (bus.DV_3 && empty) orphan_flag_q <= 1'b1;
            if (pop && !frame_load) drop_flag_q <= 1'b1;
        end
    end

    assign fault_cnt   = fault_cnt_q;
    assign total_cnt   = total_cnt_q;
    assign fault_flag  = fault_flag_q;
    assign ovf_flag    = ovf_flag_q;
    assign orphan_flag = orphan_flag_q;
    assign drop_flag   = drop_flag_q;
endmodule

// File: tb/tb_glitch_result_checker.sv
// Scoreboard bench for glitch_result_checker: golden and frame-byte queues filled on stimulus,
// frame bytes popped and compared at each TX handshake.
module tb_glitch_result_checker;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        clr_cnt;
    logic [15:0] fault_cnt, total_cnt;
    logic        fault_flag, ovf_flag, orphan_flag, drop_flag;

    glitch_result_checker_if #(.WIDTH(8)) bus ();

    glitch_result_checker #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .glitched_clk (clk),
        .rst          (rst),
        .bus          (bus),
        .clr_cnt      (clr_cnt),
        .fault_cnt    (fault_cnt),
        .total_cnt    (total_cnt),
        .fault_flag   (fault_flag),
        .ovf_flag     (ovf_flag),
        .orphan_flag  (orphan_flag),
        .drop_flag    (drop_flag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  gold_q [$];
    logic [7:0]  exp_bytes [$];
    logic [15:0] m_fault, m_total;
    bit          m_fault_flag, m_ovf, m_orphan, m_drop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfers complete at the next posedge; inputs only change just after posedges.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            if (exp_bytes.size() == 0) begin
                check("tx_extra", {31'b0, bus.tx_valid}, 32'd0);
            end else begin
                e = exp_bytes.pop_front();
                check("tx_byte", {24'b0, bus.tx_data}, {24'b0, e});
            end
        end
    end

    task automatic model_reset();
        m_fault = '0; m_total = '0;
        m_fault_flag = 0; m_ovf = 0; m_orphan = 0; m_drop = 0;
    endtask

    task automatic step(input bit do_op, input logic [7:0] a, input logic [7:0] b,
                        input bit do_dv, input logic [7:0] f, input bit drop, input bit clr);
        logic [7:0] g;
        bit popping;
        bus.op_valid = do_op; bus.op_a = a; bus.op_b = b;
        bus.DV_3 = do_dv; bus.finout = f; clr_cnt = clr;
        popping = do_dv && (gold_q.size() != 0);
        if (do_dv && !popping) m_orphan = 1;
        if (popping) begin
            g = gold_q.pop_front();
            if (m_total != 16'hFFFF) m_total++;
            if (f != g) begin
                if (m_fault != 16'hFFFF) m_fault++;
                m_fault_flag = 1;
            end
            if (drop) m_drop = 1;
            else begin
                exp_bytes.push_back((f != g) ? 8'h5A : 8'hA5);
                exp_bytes.push_back(f);
                exp_bytes.push_back(g);
            end
        end
        if (do_op) begin
            if (gold_q.size() < DEPTH) begin
                g = a + b;
                gold_q.push_back(g);
            end else begin
                m_ovf = 1;
            end
        end
        if (clr) model_reset();
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.DV_3 = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_bytes.size() == 0 && bus.tx_valid == 1'b0) break;
            @(posedge clk); #1;
        end
        check("drain_valid", {31'b0, bus.tx_valid}, 32'd0);
        check("drain_left", exp_bytes.size(), 32'd0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_total"},  {16'b0, total_cnt}, {16'b0, m_total});
        check({tag, "_fault"},  {16'b0, fault_cnt}, {16'b0, m_fault});
        check({tag, "_fflag"},  {31'b0, fault_flag}, {31'b0, m_fault_flag});
        check({tag, "_ovf"},    {31'b0, ovf_flag}, {31'b0, m_ovf});
        check({tag, "_orphan"}, {31'b0, orphan_flag}, {31'b0, m_orphan});
        check({tag, "_drop"},   {31'b0, drop_flag}, {31'b0, m_drop});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b0; clr_cnt = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.op_valid = 1'b0;
        bus.finout = '0; bus.DV_3 = 1'b0; bus.tx_ready = 1'b0;

        // T1: reset
        idle(2);
        check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
        check_status("rst");
        rst = 1'b1;
        idle(1);

        // T2: matching compare
        bus.tx_ready = 1'b1;
        step(1, 8'h12, 8'h34, 0, 8'h00, 0, 0);
        idle(2);
        step(0, 8'h00, 8'h00, 1, 8'h46, 0, 0);
        drain();
        check_status("t2");

        // T3: golden wraps, observed mismatch
        step(1, 8'hF0, 8'h20, 0, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 1, 8'h11, 0, 0);
        drain();
        check_status("t3");

        // T4: overflow, in-order compares, orphan
        step(0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
        for (int i = 1; i <= 5; i++) step(1, 8'(3 * i), 8'(i), 0, 8'h00, 0, 0);
        check_status("t4_ovf");
        for (int i = 1; i <= 4; i++) begin
            step(0, 8'h00, 8'h00, 1, 8'(4 * i), 0, 0);
            drain();
        end
        step(0, 8'h00, 8'h00, 1, 8'h77, 0, 0);
        idle(2);
        check_status("t4_orphan");
        drain();

        // T5: back-pressure holds the header, second compare is dropped
        step(0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
        bus.tx_ready = 1'b0;
        step(1, 8'h01, 8'h02, 0, 8'h00, 0, 0);
        step(1, 8'h03, 8'h04, 1, 8'h03, 0, 0);
        step(0, 8'h00, 8'h00, 1, 8'h07, 1, 0);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_data", {24'b0, bus.tx_data}, 32'h0000_00A5);
            check("t5_hold_valid", {31'b0, bus.tx_valid}, 32'd1);
            idle(1);
        end
        check_status("t5");
        bus.tx_ready = 1'b1;
        drain();

        // T6: fault counter saturation, then clear coincident with a compare
        step(0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
        bus.tx_ready = 1'b0;
        step(1, 8'h01, 8'h01, 0, 8'h00, 0, 0);
        for (int k = 0; k < 65536; k++) step(1, 8'h01, 8'h01, 1, 8'h00, (k != 0), 0);
        check_status("t6_sat");
        bus.tx_ready = 1'b1;
        drain();
        step(0, 8'h00, 8'h00, 1, 8'h02, 0, 1);
        check_status("t6_clr");
        drain();

        // Reset mid-frame abandons the frame and flushes the FIFO
        bus.tx_ready = 1'b0;
        step(1, 8'h10, 8'h20, 0, 8'h00, 0, 0);
        step(1, 8'h01, 8'h02, 0, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 1, 8'h30, 0, 0);
        rst = 1'b0;
        idle(1);
        check("midrst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        rst = 1'b1;
        exp_bytes.delete();
        gold_q.delete();
        model_reset();
        check_status("midrst");
        bus.tx_ready = 1'b1;
        step(1, 8'h05, 8'h06, 0, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 1, 8'h0B, 0, 0);
        drain();
        check_status("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
